// File: rtl/fetch_entry_queue_pkg.sv
// Shared types and constants for the fetch-entry queue.
// Provides fetch_entry_t, the lane count and a prefix-check helper.
package fetch_entry_queue_pkg;

    localparam int ISSUE_WIDTH = 2;
    localparam int ISSUE_CNT_W = $clog2(ISSUE_WIDTH + 1);

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] instruction;
    } fetch_entry_t;

    // True when the set bits of v form a contiguous run starting at lane 0.
    function automatic logic is_prefix(logic [ISSUE_WIDTH-1:0] v);
        return ((v & (v + ISSUE_WIDTH'(1))) == '0);
    endfunction

endpackage

// File: rtl/fetch_entry_queue_if.sv
// Lane handshake bundle between frontend, queue and decode.
// master: queue side (accepts pushes, presents entries).
// slave : environment side (frontend pushes, decode acknowledges).
//   push_valid/push_entry/push_ready        : frontend -> queue
//   fetch_entry/fetch_entry_valid/_ready    : queue -> decode
interface fetch_entry_queue_if;
    import fetch_entry_queue_pkg::*;

    logic         [ISSUE_WIDTH-1:0] push_valid;
    fetch_entry_t [ISSUE_WIDTH-1:0] push_entry;
    logic                           push_ready;
    fetch_entry_t [ISSUE_WIDTH-1:0] fetch_entry;
    logic         [ISSUE_WIDTH-1:0] fetch_entry_valid;
    logic         [ISSUE_WIDTH-1:0] fetch_entry_ready;

    modport master (
        input  push_valid,
        input  push_entry,
        input  fetch_entry_ready,
        output push_ready,
        output fetch_entry,
        output fetch_entry_valid
    );

    modport slave (
        output push_valid,
        output push_entry,
        output fetch_entry_ready,
        input  push_ready,
        input  fetch_entry,
        input  fetch_entry_valid
    );

endinterface

// File: rtl/fetch_entry_queue_lzc.sv
// Trailing-zero counter; fed with an inverted vector it counts trailing ones.
// in_i: vector to scan from bit 0, cnt_o: number of zeros below the first one.
module fetch_entry_queue_lzc #(
    parameter int WIDTH = 2,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CW-1:0]    cnt_o
);

    logic done;

    always_comb begin
        cnt_o = '0;
        done  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!done) begin
                if (in_i[i]) begin
                    done = 1'b1;
                end else begin
                    cnt_o = cnt_o + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/fetch_entry_queue.sv
// Multi-lane circular instruction queue between frontend and decode.
// clk_i/rst_i: clock, async active-high reset; flush_i: drop all entries;
// bus (master): push and fetch-entry lane handshakes; count_o: occupancy.
module fetch_entry_queue
    import fetch_entry_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    fetch_entry_queue_if.master        bus,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t mem_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [ISSUE_CNT_W-1:0] push_ones, pop_ones;
    logic [ISSUE_CNT_W-1:0] n_push, n_pop;
    logic                   push_ready;
    logic [ISSUE_WIDTH-1:0] valid;

    fetch_entry_queue_lzc #(.WIDTH(ISSUE_WIDTH)) u_push_cnt (
        .in_i  (~bus.push_valid),
        .cnt_o (push_ones)
    );

    fetch_entry_queue_lzc #(.WIDTH(ISSUE_WIDTH)) u_pop_cnt (
        .in_i  (~(bus.fetch_entry_ready & valid)),
        .cnt_o (pop_ones)
    );

    // Uses the pre-pop count so a push can never overflow,
    // even when decode drains in the same cycle.
    always_comb begin
        push_ready = (count_q <= CW'(DEPTH - ISSUE_WIDTH));
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            valid[i] = (CW'(i) < count_q);
        end
    end

    assign n_push = push_ready ? push_ones : '0;
    assign n_pop  = pop_ones;

    assign bus.push_ready        = push_ready;
    assign bus.fetch_entry_valid = valid;
    assign count_o               = count_q;

    for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_out
        assign bus.fetch_entry[i] = mem_q[rd_ptr_q + PW'(i)];
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q + PW'(n_pop);
        wr_ptr_d = wr_ptr_q + PW'(n_push);
        count_d  = count_q + CW'(n_push) - CW'(n_pop);
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                mem_q[j] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (!flush_i) begin
                for (int k = 0; k < ISSUE_WIDTH; k++) begin
                    if (ISSUE_CNT_W'(k) < n_push) begin
                        mem_q[wr_ptr_q + PW'(k)] <= bus.push_entry[k];
                    end
                end
            end
        end
    end

    a_count_bound : assert property (
        @(posedge clk_i) disable iff (rst_i) count_q <= CW'(DEPTH));

    a_push_prefix : assert property (
        @(posedge clk_i) disable iff (rst_i) is_prefix(bus.push_valid));

    a_ready_prefix : assert property (
        @(posedge clk_i) disable iff (rst_i)
        is_prefix(bus.fetch_entry_ready));

endmodule

// File: tb/tb_fetch_entry_queue.sv
// Randomised scoreboard bench for fetch_entry_queue.
// Reference model: a queue of expected entries plus an occupancy count.
module tb_fetch_entry_queue;
    import fetch_entry_queue_pkg::*;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [3:0] count;

    fetch_entry_queue_if bus();

    fetch_entry_queue #(.DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus.master),
        .count_o (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vis_cnt = 0;
    int nxt_cnt = 0;
    bit mon_en = 1'b0;
    fetch_entry_t exp_q[$];

    function automatic int tones(input logic [1:0] v);
        if (v[0] == 1'b0) return 0;
        if (v[1] == 1'b0) return 1;
        return 2;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus, driven just after the rising edge.
    task automatic step(input logic fl, input logic [1:0] pv,
                        input logic [1:0] rd);
        int npush;
        int npop;
        @(posedge clk);
        #1;
        vis_cnt = nxt_cnt;
        flush = fl;
        bus.push_valid = pv;
        bus.fetch_entry_ready = rd;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            bus.push_entry[k] = {$urandom, $urandom};
        end
        npush = (DEPTH - vis_cnt >= ISSUE_WIDTH) ? tones(pv) : 0;
        npop = imin(tones(rd), imin(vis_cnt, ISSUE_WIDTH));
        if (fl) begin
            exp_q.delete();
            nxt_cnt = 0;
        end else begin
            for (int k = 0; k < npush; k++) begin
                exp_q.push_back(bus.push_entry[k]);
            end
            nxt_cnt = vis_cnt + npush - npop;
        end
    endtask

    // Monitor: checks what the DUT presents, retires acknowledged entries.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            int nv;
            int npop;
            logic [1:0] exp_v;
            nv = imin(vis_cnt, ISSUE_WIDTH);
            exp_v = (nv == 2) ? 2'b11 : (nv == 1) ? 2'b01 : 2'b00;
            chk("count", 64'(count), 64'(vis_cnt));
            chk("valid", 64'(bus.fetch_entry_valid), 64'(exp_v));
            chk("push_ready", 64'(bus.push_ready),
                64'(DEPTH - vis_cnt >= ISSUE_WIDTH));
            if (!flush) begin
                for (int i = 0; i < nv; i++) begin
                    if (exp_q.size() > i) begin
                        chk($sformatf("lane%0d", i), bus.fetch_entry[i],
                            exp_q[i]);
                    end else begin
                        chk("sb_underflow", 64'(exp_q.size()), 64'(i + 1));
                    end
                end
                npop = imin(tones(bus.fetch_entry_ready), nv);
                for (int i = 0; i < npop; i++) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
            end
        end
    end

    function automatic logic [1:0] rand_prefix(input int bias_zero);
        int r;
        r = $urandom_range(0, 9);
        if (r < bias_zero) return 2'b00;
        return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
    endfunction

    initial begin
        bus.push_valid = '0;
        bus.push_entry = '0;
        bus.fetch_entry_ready = '0;
        #7;
        chk("rst_valid", 64'(bus.fetch_entry_valid), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_push_ready", 64'(bus.push_ready), 64'(1));
        chk("rst_lane0", bus.fetch_entry[0], 64'(0));
        chk("rst_lane1", bus.fetch_entry[1], 64'(0));
        #5;
        rst = 1'b0;
        mon_en = 1'b1;

        step(0, 2'b11, 2'b00);
        step(0, 2'b00, 2'b00);
        step(0, 2'b01, 2'b00);
        step(0, 2'b00, 2'b01);
        step(0, 2'b00, 2'b00);

        step(1, 2'b00, 2'b00);
        repeat (5) step(0, 2'b11, 2'b00);
        step(0, 2'b00, 2'b00);
        repeat (10) step(0, 2'b11, 2'b11);
        step(0, 2'b00, 2'b00);

        step(1, 2'b00, 2'b00);
        repeat (3) step(0, 2'b11, 2'b00);
        step(0, 2'b01, 2'b00);
        step(0, 2'b11, 2'b11);
        step(0, 2'b00, 2'b00);

        step(1, 2'b00, 2'b00);
        repeat (2) step(0, 2'b11, 2'b00);
        step(1, 2'b11, 2'b11);
        step(0, 2'b01, 2'b00);
        step(0, 2'b00, 2'b00);
        step(0, 2'b00, 2'b01);

        step(1, 2'b00, 2'b00);
        step(0, 2'b11, 2'b00);
        step(0, 2'b11, 2'b00);
        step(0, 2'b01, 2'b00);
        step(0, 2'b00, 2'b00);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(bus.fetch_entry_valid), 64'(0));
        chk("async_rst_count", 64'(count), 64'(0));
        chk("async_rst_push_ready", 64'(bus.push_ready), 64'(1));
        exp_q.delete();
        vis_cnt = 0;
        nxt_cnt = 0;
        #2;
        rst = 1'b0;

        for (int c = 0; c < 800; c++) begin
            int bias;
            bias = ((c / 100) % 2 == 1) ? 8 : 3;
            step(($urandom_range(0, 39) == 0), rand_prefix(2),
                 rand_prefix(bias));
        end
        step(0, 2'b00, 2'b00);
        step(0, 2'b00, 2'b00);
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
